// File: rtl/dec_key_pkg.sv
// Shared definitions for the decimal keypad debouncer: key count, default
// debounce length, FSM state encoding and a one-hot test helper.
package dec_key_pkg;

   localparam int NUM_KEYS          = 10;
   localparam int DB_CYCLES_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } key_state_e;

   localparam logic [NUM_KEYS-1:0] KEY_LSB = NUM_KEYS'(1);

   // True when exactly one key line is set.
   function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
      return (v != '0) && ((v & (v - KEY_LSB)) == '0);
   endfunction

endpackage

// File: rtl/dec_key_debounce_sync2.sv
// Two-flop synchronizer bank bringing asynchronous key lines into clk.
module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // First stage may go metastable; second stage gives it a cycle to settle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so both stages sample the pre-edge values and form a real two-stage shift.
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/dec_key_debounce.sv
// Decimal key debouncer: synchronizes ten bouncy key lines, requires a
// pattern to be stable for DB_CYCLES cycles before accepting it, flags
// multi-key presses, and holds the last accepted key one-hot for the
// downstream decimal-to-BCD encoder.
module dec_key_debounce
   import dec_key_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_raw,
   output logic [NUM_KEYS-1:0] key_onehot,
   output logic                key_valid,
   output logic                key_held,
   output logic                multi_err
);

   localparam int                CNT_W   = $clog2(DB_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic [NUM_KEYS-1:0] key_sync;

   key_state_e          state_q,      state_d;
   logic [NUM_KEYS-1:0] snap_q,       snap_d;
   logic [CNT_W-1:0]    cnt_q,        cnt_d;
   logic [NUM_KEYS-1:0] key_onehot_q, key_onehot_d;
   logic                key_valid_q,  key_valid_d;
   logic                key_held_q,   key_held_d;
   logic                multi_err_q,  multi_err_d;

   sync2 #(
      .WIDTH (NUM_KEYS)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (key_raw),
      .q   (key_sync)
   );

   // Next-state, counter, snapshot and registered-output logic.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned, which would infer a latch.
      state_d      = state_q;
      snap_d       = snap_q;
      cnt_d        = cnt_q;
      key_onehot_d = key_onehot_q;
      key_valid_d  = 1'b0;
      multi_err_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (key_sync != '0) begin
               snap_d  = key_sync;
               cnt_d   = '0;
               state_d = ST_DEBOUNCE;
            end
         end

         ST_DEBOUNCE: begin
            if (key_sync == '0) begin
               state_d = ST_IDLE;
            end else if (key_sync != snap_q) begin
               // Pattern moved while bouncing: restart the stability window.
               snap_d = key_sync;
               cnt_d  = '0;
            end else if (cnt_q < CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end else if (is_onehot(snap_q)) begin
               key_onehot_d = snap_q;
               key_valid_d  = 1'b1;
               state_d      = ST_PRESSED;
            end else begin
               // Stable chord: report it, keep the previous key, and wait
               // for a full release before looking for a new press.
               multi_err_d = 1'b1;
               cnt_d       = '0;
               state_d     = ST_RELEASE;
            end
         end

         ST_PRESSED: begin
            // Other nonzero patterns are ignored here; only a release
            // leads anywhere.
            if (key_sync == '0) begin
               cnt_d   = '0;
               state_d = ST_RELEASE;
            end
         end

         ST_RELEASE: begin
            if (key_sync != '0) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      key_held_d = (state_d == ST_PRESSED);
   end

   // State and output registers; reset returns everything to idle at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         snap_q       <= '0;
         cnt_q        <= '0;
         key_onehot_q <= '0;
         key_valid_q  <= 1'b0;
         key_held_q   <= 1'b0;
         multi_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         snap_q       <= snap_d;
         cnt_q        <= cnt_d;
         key_onehot_q <= key_onehot_d;
         key_valid_q  <= key_valid_d;
         key_held_q   <= key_held_d;
         multi_err_q  <= multi_err_d;
      end
   end

   assign key_onehot = key_onehot_q;
   assign key_valid  = key_valid_q;
   assign key_held   = key_held_q;
   assign multi_err  = multi_err_q;

endmodule

// File: tb/tb_dec_key_debounce.sv
// Directed bench for dec_key_debounce with DB_CYCLES = 4.
module tb_dec_key_debounce;
   import dec_key_pkg::*;

   localparam int DB = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic [NUM_KEYS-1:0] key_raw;
   logic [NUM_KEYS-1:0] key_onehot;
   logic                key_valid;
   logic                key_held;
   logic                multi_err;

   int total     = 0;
   int passed    = 0;
   int failed    = 0;
   int valid_cnt = 0;
   int merr_cnt  = 0;
   int viol_cnt  = 0;
   logic prev_v  = 1'b0;
   logic prev_m  = 1'b0;
   int base_v;
   int base_m;

   always #5 clk = ~clk;

   dec_key_debounce #(
      .DB_CYCLES (DB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key_raw    (key_raw),
      .key_onehot (key_onehot),
      .key_valid  (key_valid),
      .key_held   (key_held),
      .multi_err  (multi_err)
   );

   // Pulse counters and pulse-shape monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (key_valid === 1'b1) valid_cnt <= valid_cnt + 1;
      if (multi_err === 1'b1) merr_cnt  <= merr_cnt + 1;
      if ((key_valid && multi_err) || (key_valid && prev_v) || (multi_err && prev_m))
         viol_cnt <= viol_cnt + 1;
      prev_v <= key_valid;
      prev_m <= multi_err;
   end

   // Reference decimal-to-BCD encoder driven from key_onehot.
   function automatic logic [3:0] enc(input logic [NUM_KEYS-1:0] oh);
      logic [3:0] y;
      y = 4'd0;
      for (int i = 0; i < NUM_KEYS; i++)
         if (oh[i]) y = 4'(i);
      return y;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst     = 1'b1;
      key_raw = '0;
      step(2);
      check("rst_onehot", 32'(key_onehot), 32'h0);
      check("rst_valid",  32'(key_valid),  32'h0);
      check("rst_held",   32'(key_held),   32'h0);
      check("rst_merr",   32'(multi_err),  32'h0);
      rst = 1'b0;
      step(2);

      // Clean press of key 3: pulse after edge 7.
      key_raw = 10'b0000001000;
      step(6);
      check("clean_early", 32'(key_valid), 32'h0);
      step(1);
      check("clean_valid",  32'(key_valid),       32'h1);
      check("clean_onehot", 32'(key_onehot),      32'h008);
      check("clean_enc",    32'(enc(key_onehot)), 32'd3);
      check("clean_held",   32'(key_held),        32'h1);
      step(1);
      check("clean_pulse1", 32'(key_valid), 32'h0);
      step(3);
      check("clean_held_on", 32'(key_held), 32'h1);

      // Release key 3, press key 5 two cycles later: never accepted.
      base_v  = valid_cnt;
      key_raw = '0;
      step(2);
      key_raw = 10'b0000100000;
      step(8);
      check("rel_held_off",  32'(key_held),        32'h0);
      check("rel_hold_key",  32'(key_onehot),      32'h008);
      check("rel_no_accept", 32'(valid_cnt - base_v), 32'd0);
      key_raw = '0;
      step(8);
      key_raw = 10'b0000100000;
      step(6);
      check("k5_early", 32'(key_valid), 32'h0);
      step(1);
      check("k5_valid",  32'(key_valid),       32'h1);
      check("k5_onehot", 32'(key_onehot),      32'h020);
      check("k5_enc",    32'(enc(key_onehot)), 32'd5);
      key_raw = '0;
      step(8);

      // Key 7 bounces every 2 cycles, then stays pressed.
      base_v = valid_cnt;
      for (int i = 0; i < 4; i++) begin
         key_raw = 10'b0010000000;
         step(2);
         key_raw = '0;
         step(2);
      end
      key_raw = 10'b0010000000;
      step(6);
      check("bnc_early",    32'(key_valid),          32'h0);
      check("bnc_no_pulse", 32'(valid_cnt - base_v), 32'd0);
      step(1);
      check("bnc_valid",  32'(key_valid),       32'h1);
      check("bnc_onehot", 32'(key_onehot),      32'h080);
      check("bnc_enc",    32'(enc(key_onehot)), 32'd7);
      step(2);
      check("bnc_one_pulse", 32'(valid_cnt - base_v), 32'd1);
      key_raw = '0;
      step(8);

      // Keys 9 and 1 together: multi_err, previous key kept.
      base_v  = valid_cnt;
      base_m  = merr_cnt;
      key_raw = 10'b1000000010;
      step(6);
      check("multi_early", 32'(multi_err), 32'h0);
      step(1);
      check("multi_err",    32'(multi_err),  32'h1);
      check("multi_valid",  32'(key_valid),  32'h0);
      check("multi_onehot", 32'(key_onehot), 32'h080);
      check("multi_held",   32'(key_held),   32'h0);
      step(1);
      check("multi_pulse1", 32'(multi_err), 32'h0);
      step(4);
      check("multi_count",    32'(merr_cnt - base_m),  32'd1);
      check("multi_no_valid", 32'(valid_cnt - base_v), 32'd0);
      key_raw = '0;
      step(8);

      // Reset in DEBOUNCE with cnt = 2, key 4 kept pressed throughout.
      key_raw = 10'b0000010000;
      step(5);
      rst = 1'b1;
      #1;
      check("mrst_onehot", 32'(key_onehot), 32'h0);
      check("mrst_valid",  32'(key_valid),  32'h0);
      check("mrst_held",   32'(key_held),   32'h0);
      check("mrst_merr",   32'(multi_err),  32'h0);
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("mrst_in_rst_valid", 32'(key_valid), 32'h0);
      end
      rst = 1'b0;
      step(6);
      check("mrst_early", 32'(key_valid), 32'h0);
      step(1);
      check("mrst_valid_after", 32'(key_valid),       32'h1);
      check("mrst_onehot_after", 32'(key_onehot),     32'h010);
      check("mrst_enc",         32'(enc(key_onehot)), 32'd4);
      key_raw = '0;
      step(8);

      // Sweep every key with a clean press and release.
      base_v = valid_cnt;
      for (int k = 0; k < NUM_KEYS; k++) begin
         key_raw    = '0;
         key_raw[k] = 1'b1;
         step(7);
         check("sweep_valid", 32'(key_valid),       32'h1);
         check("sweep_enc",   32'(enc(key_onehot)), 32'(k));
         key_raw = '0;
         step(8);
      end
      check("sweep_count", 32'(valid_cnt - base_v), 32'd10);
      check("pulse_shape", 32'(viol_cnt), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
